mult_share_arbiter: RTL and testbench

Round-robin scheduler that shares one multi-cycle signed shift multiplier (`integrationSignedShiftMultiplier`-class datapath) among NREQ requesters. It accepts one operand pair at a time over a per-requester valid/ready handshake and issues it to the multiplier with a one-cycle start pulse. It waits the fixed multiplier latency, then returns the 2·WIDTH-bit product tagged with the requester index over a valid/ready response port. The block sits between the client blocks and the single shared multiplier instance.

---
 rtl/mult_share_arbiter.sv | 120 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one multi-cycle signed multiplier among
// NREQ requesters, returning each product tagged with its requester index.
module mult_share_arbiter #(
    parameter  int WIDTH   = 32,
    parameter  int NREQ    = 4,
    parameter  int MUL_LAT = 34,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_x,
    input  logic [NREQ*WIDTH-1:0]   req_y,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_z,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_x,
    output logic [WIDTH-1:0]        mul_y,
    input  logic [2*WIDTH-1:0]      mul_z,
    output logic                    busy,
    output logic [15:0]             done_count
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [CW-1:0]   cnt;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;

    // Search starts at ptr so the requester after the last one served wins ties.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_x       = '0;
        sel_y       = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
                sel_x       = req_x[idx*WIDTH +: WIDTH];
                sel_y       = req_y[idx*WIDTH +: WIDTH];
            end
        end
    end

    // Gated by reset so no grant is advertised while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (reset && state == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            mul_x      <= '0;
            mul_y      <= '0;
            mul_start  <= 1'b0;
            rsp_id     <= '0;
            rsp_z      <= '0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        mul_x     <= sel_x;
                        mul_y     <= sel_y;
                        rsp_id    <= grant_idx;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start <= 1'b0;
                    cnt       <= CW'(MUL_LAT - 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_z     <= mul_z;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        busy       <= 1'b0;
                        done_count <= done_count + 16'd1;
                        ptr        <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed and randomised checks of mult_share_arbiter against a behavioural
// fixed-latency signed multiplier.
module tb_mult_share_arbiter;

    localparam int WIDTH   = 32;
    localparam int NREQ    = 4;
    localparam int MUL_LAT = 34;
    localparam int IDW     = 2;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_x = '0;
    logic [NREQ*WIDTH-1:0] req_y = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_z;
    logic                  mul_start;
    logic [WIDTH-1:0]      mul_x;
    logic [WIDTH-1:0]      mul_y;
    logic [2*WIDTH-1:0]    mul_z;
    logic                  busy;
    logic [15:0]           done_count;

    int tests    = 0;
    int failures = 0;
    int exp_done = 0;

    mult_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_z(rsp_z),
        .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
        .busy(busy), .done_count(done_count)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // The product is only presented in the cycle before the capture edge, so an
    // early or late capture picks up the filler pattern instead.
    logic [63:0] mprod = '0;
    int          mcnt  = 0;
    always @(posedge clock) begin
        if (mul_start) begin
            mprod <= mul_ref(mul_x, mul_y);
            mcnt  <= MUL_LAT;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
        end
    end
    assign mul_z = (mcnt == 1) ? mprod : 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset    = 1'b1;
        exp_done = 0;
    endtask

    task automatic set_req(input int g, input logic [31:0] x, input logic [31:0] y);
        req_valid[g]         = 1'b1;
        req_x[g*WIDTH +: WIDTH] = x;
        req_y[g*WIDTH +: WIDTH] = y;
    endtask

    // Called at a negedge with the DUT idle and requests already driven.
    task automatic serve(input int g, input logic [31:0] x, input logic [31:0] y, input logic [63:0] z);
        int lat;
        int extra_starts;
        #1;
        check_output("grant", 64'(req_ready), 64'(1) << g);
        @(posedge clock);
        @(negedge clock);
        req_valid[g] = 1'b0;
        check_output("mul_start", 64'(mul_start), 64'd1);
        check_output("mul_x", 64'(mul_x), 64'(x));
        check_output("mul_y", 64'(mul_y), 64'(y));
        check_output("busy_op", 64'(busy), 64'd1);
        check_output("ready_op", 64'(req_ready), 64'd0);
        lat = 0;
        extra_starts = 0;
        while (!rsp_valid && lat < 200) begin
            @(posedge clock);
            @(negedge clock);
            lat++;
            if (mul_start) extra_starts++;
        end
        check_output("latency", 64'(lat), 64'(MUL_LAT + 1));
        check_output("extra_start", 64'(extra_starts), 64'd0);
        check_output("rsp_id", 64'(rsp_id), 64'(g));
        check_output("rsp_z", rsp_z, z);
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        exp_done++;
        check_output("rsp_done", 64'(rsp_valid), 64'd0);
        check_output("done_count", 64'(done_count), 64'(16'(exp_done)));
    endtask

    logic [NREQ-1:0] pending;
    logic [31:0]     px [NREQ];
    logic [31:0]     py [NREQ];
    int              wait_ops [NREQ];

    initial begin
        logic [63:0] held_z;
        logic [IDW-1:0] held_id;
        int bad, cyc, exp_ptr, g, max_wait;
        bit found, done;

        // Reset values
        #2;
        check_output("rst_ready", 64'(req_ready), 64'd0);
        check_output("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("rst_rsp_z", rsp_z, 64'd0);
        check_output("rst_mul_start", 64'(mul_start), 64'd0);
        check_output("rst_mul_x", 64'(mul_x), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_done", 64'(done_count), 64'd0);
        do_reset();

        // Single ops, including signed operands
        set_req(0, 32'd2, 32'd4);
        serve(0, 32'd2, 32'd4, 64'd8);
        set_req(0, 32'hFFFF_FFFE, 32'd4);
        serve(0, 32'hFFFF_FFFE, 32'd4, 64'hFFFF_FFFF_FFFF_FFF8);
        set_req(0, 32'hFFFF_FFF9, 32'hFFFF_FFFC);
        serve(0, 32'hFFFF_FFF9, 32'hFFFF_FFFC, 64'd28);
        set_req(0, 32'h0008_0002, 32'h0400_0004);
        serve(0, 32'h0008_0002, 32'h0400_0004, 64'h0000_2000_0820_0008);

        // Contention from reset: 0,2,3 then 0,3
        do_reset();
        set_req(0, 32'd5, 32'd6);
        set_req(2, 32'hFFFF_FFFD, 32'd100);
        set_req(3, 32'h7FFF_FFFF, 32'd2);
        serve(0, 32'd5, 32'd6, 64'd30);
        serve(2, 32'hFFFF_FFFD, 32'd100, 64'hFFFF_FFFF_FFFF_FED4);
        serve(3, 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE);
        set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        set_req(3, 32'h8000_0000, 32'h8000_0000);
        serve(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        serve(3, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        // Backpressure: hold rsp_ready low for 50 cycles with another request pending
        set_req(1, 32'd11, 32'd13);
        #1;
        check_output("bp_grant", 64'(req_ready), 64'b0010);
        @(posedge clock);
        @(negedge clock);
        req_valid[1] = 1'b0;
        set_req(2, 32'd9, 32'hFFFF_FFF7);
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        check_output("bp_latency", 64'(cyc), 64'(MUL_LAT + 1));
        held_z  = rsp_z;
        held_id = rsp_id;
        check_output("bp_z", held_z, 64'd143);
        check_output("bp_id", 64'(held_id), 64'd1);
        bad = 0;
        repeat (50) begin
            @(posedge clock);
            @(negedge clock);
            if (rsp_z !== held_z || rsp_id !== held_id || req_ready !== '0 ||
                mul_start !== 1'b0 || rsp_valid !== 1'b1) bad++;
        end
        check_output("bp_stall_stable", 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        exp_done++;
        check_output("bp_busy_drop", 64'(busy), 64'd0);
        check_output("bp_done", 64'(done_count), 64'(16'(exp_done)));
        serve(2, 32'd9, 32'hFFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFAF);

        // Reset mid-WAIT abandons the op
        set_req(0, 32'd100, 32'd100);
        @(posedge clock);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_output("mid_rst_ready", 64'(req_ready), 64'd0);
        check_output("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("mid_rst_busy", 64'(busy), 64'd0);
        check_output("mid_rst_mul_x", 64'(mul_x), 64'd0);
        check_output("mid_rst_mul_y", 64'(mul_y), 64'd0);
        check_output("mid_rst_rsp_z", rsp_z, 64'd0);
        check_output("mid_rst_done", 64'(done_count), 64'd0);
        req_valid = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset    = 1'b1;
        exp_done = 0;
        bad = 0;
        repeat (40) begin
            @(posedge clock);
            @(negedge clock);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check_output("no_stale_rsp", 64'(bad), 64'd0);
        set_req(1, 32'd3, 32'hFFFF_FFFD);
        serve(1, 32'd3, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF7);

        // Random stress against round-robin and multiplier models
        do_reset();
        pending  = '0;
        exp_ptr  = 0;
        max_wait = 0;
        for (int i = 0; i < NREQ; i++) wait_ops[i] = 0;
        for (int op = 0; op < 1000; op++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    pending[i] = 1'b1;
                    px[i] = $urandom;
                    py[i] = $urandom;
                    wait_ops[i] = 0;
                end
            end
            if (pending == '0) begin
                g = $urandom_range(0, NREQ - 1);
                pending[g] = 1'b1;
                px[g] = $urandom;
                py[g] = $urandom;
                wait_ops[g] = 0;
            end
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = pending[i];
                req_x[i*WIDTH +: WIDTH] = px[i];
                req_y[i*WIDTH +: WIDTH] = py[i];
            end
            found = 1'b0;
            g = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && pending[(exp_ptr + k) % NREQ]) begin
                    found = 1'b1;
                    g = (exp_ptr + k) % NREQ;
                end
            end
            #1;
            check_output("st_grant", 64'(req_ready), 64'(1) << g);
            if (wait_ops[g] > max_wait) max_wait = wait_ops[g];
            @(posedge clock);
            @(negedge clock);
            pending[g]   = 1'b0;
            req_valid[g] = 1'b0;
            for (int i = 0; i < NREQ; i++) if (pending[i]) wait_ops[i]++;
            done = 1'b0;
            cyc  = 0;
            while (!done && cyc < 1000) begin
                rsp_ready = 1'($urandom_range(0, 1));
                #1;
                if (rsp_valid && rsp_ready) begin
                    check_output("st_rsp_id", 64'(rsp_id), 64'(g));
                    check_output("st_rsp_z", rsp_z, mul_ref(px[g], py[g]));
                    done = 1'b1;
                end
                @(posedge clock);
                @(negedge clock);
                cyc++;
            end
            if (!done) check_output("st_timeout", 64'(cyc), 64'd0);
            rsp_ready = 1'b0;
            exp_ptr = (g + 1) % NREQ;
            exp_done++;
        end
        check_output("st_done_count", 64'(done_count), 64'(16'(exp_done)));
        check_output("st_max_wait_ok", 64'(max_wait <= NREQ - 1), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
